// File: rtl/usrt_pkg.sv
// Shared definitions for the parametrised USRT receiver: parity modes,
// receive FSM state encoding and a constant-evaluable ceil(log2) helper.
package usrt_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO. The head word is visible on dout whenever
// the FIFO is not empty; a push into a full FIFO is dropped unless a pop
// happens in the same cycle.
module sync_fifo
  import usrt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/usrt_rec_param.sv
// Parametrised USRT receiver: oversamples usrt_clk/usrt_rx, assembles
// DATA_BITS-wide frames with optional parity, and queues them with flags.
module usrt_rec_param
  import usrt_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int SAMPLE_EDGE = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 usrt_rx,
  input  logic                 usrt_clk,
  input  logic                 ovf_clr,
  input  logic                 dout_ready,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_perr,
  output logic                 dout_ferr,
  output logic                 dout_valid,
  output logic                 ovf
);
  localparam int CNT_W = clog2(DATA_BITS);
  localparam int FW    = DATA_BITS + 2;

  logic [1:0]           clk_sync_reg;
  logic [1:0]           rx_sync_reg;
  logic                 clk_prev_reg;
  logic                 rx_d_reg;
  logic                 smp_reg;

  rx_state_t            state_reg, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 acc_reg, acc_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 push_reg, push_next;
  logic                 ovf_reg, ovf_next;

  logic [FW-1:0]        fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  // rx gets one extra flop so it lines up with the registered smp strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg <= 2'b11;
      rx_sync_reg  <= 2'b11;
      clk_prev_reg <= 1'b1;
      rx_d_reg     <= 1'b1;
      smp_reg      <= 1'b0;
    end else begin
      clk_sync_reg <= {clk_sync_reg[0], usrt_clk};
      rx_sync_reg  <= {rx_sync_reg[0], usrt_rx};
      clk_prev_reg <= clk_sync_reg[1];
      rx_d_reg     <= rx_sync_reg[1];
      smp_reg      <= (SAMPLE_EDGE != 0) ? (clk_sync_reg[1] & ~clk_prev_reg)
                                         : (~clk_sync_reg[1] & clk_prev_reg);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      acc_reg   <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      push_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
      push_reg  <= push_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    push_next  = 1'b0;
    if (smp_reg) begin
      case (state_reg)
        ST_IDLE: begin
          if (!rx_d_reg) begin
            state_next = ST_DATA;
            cnt_next   = '0;
            acc_next   = 1'b0;
            perr_next  = 1'b0;
          end
        end
        ST_DATA: begin
          shift_next = {rx_d_reg, shift_reg[DATA_BITS-1:1]};
          acc_next   = acc_reg ^ rx_d_reg;
          cnt_next   = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(DATA_BITS - 1))
            state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          perr_next  = (PARITY == PAR_ODD) ? ~(acc_reg ^ rx_d_reg) : (acc_reg ^ rx_d_reg);
          state_next = ST_STOP;
        end
        ST_STOP: begin
          ferr_next  = ~rx_d_reg;
          push_next  = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // A simultaneous pop frees the slot, so only push-on-full without ready drops.
  always_comb begin
    ovf_next = ovf_reg;
    if (push_reg && fifo_full && !dout_ready) ovf_next = 1'b1;
    else if (ovf_clr)                         ovf_next = 1'b0;
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_reg),
    .pop   (dout_ready),
    .din   ({ferr_reg, perr_reg, shift_reg}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign dout       = fifo_dout[DATA_BITS-1:0];
  assign dout_perr  = fifo_dout[DATA_BITS];
  assign dout_ferr  = fifo_dout[DATA_BITS+1];
  assign dout_valid = ~fifo_empty;
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_usrt_rec_param.sv
// Scoreboard bench for usrt_rec_param: three configurations are driven with
// serial frames; expected words are queued at send time and checked on pop.
module tb_usrt_rec_param;
  localparam int NB[3]  = '{8, 8, 12};
  localparam int PM[3]  = '{0, 1, 2};
  localparam int SE[3]  = '{0, 0, 1};
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rx[3];
  logic uclk[3];
  logic rdy[3];
  logic oclr[3];

  logic [7:0]  dout0, dout1;
  logic [11:0] dout2;
  logic perr0, perr1, perr2, ferr0, ferr1, ferr2;
  logic val0, val1, val2, ovf0, ovf1, ovf2;

  int errors = 0;
  int checks = 0;
  logic [17:0] q0[$], q1[$], q2[$];
  logic exp_ovf[3];

  usrt_rec_param #(.DATA_BITS(8), .PARITY(0), .SAMPLE_EDGE(0), .FIFO_DEPTH(DEPTH)) u0 (
    .clk(clk), .rst(rst), .usrt_rx(rx[0]), .usrt_clk(uclk[0]), .ovf_clr(oclr[0]),
    .dout_ready(rdy[0]), .dout(dout0), .dout_perr(perr0), .dout_ferr(ferr0),
    .dout_valid(val0), .ovf(ovf0));

  usrt_rec_param #(.DATA_BITS(8), .PARITY(1), .SAMPLE_EDGE(0), .FIFO_DEPTH(DEPTH)) u1 (
    .clk(clk), .rst(rst), .usrt_rx(rx[1]), .usrt_clk(uclk[1]), .ovf_clr(oclr[1]),
    .dout_ready(rdy[1]), .dout(dout1), .dout_perr(perr1), .dout_ferr(ferr1),
    .dout_valid(val1), .ovf(ovf1));

  usrt_rec_param #(.DATA_BITS(12), .PARITY(2), .SAMPLE_EDGE(1), .FIFO_DEPTH(DEPTH)) u2 (
    .clk(clk), .rst(rst), .usrt_rx(rx[2]), .usrt_clk(uclk[2]), .ovf_clr(oclr[2]),
    .dout_ready(rdy[2]), .dout(dout2), .dout_perr(perr2), .dout_ferr(ferr2),
    .dout_valid(val2), .ovf(ovf2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_val(input int i);
    case (i)
      0:       return val0;
      1:       return val1;
      default: return val2;
    endcase
  endfunction

  function automatic logic get_ovf(input int i);
    case (i)
      0:       return ovf0;
      1:       return ovf1;
      default: return ovf2;
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int i, input logic [17:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // hook 1: pulse ready on the push cycle; hook 2: check valid latency around the push.
  task automatic send_bit(input int i, input logic b, input int hook);
    uclk[i] = (SE[i] == 0);
    rx[i]   = b;
    cyc(8);
    uclk[i] = (SE[i] != 0);
    if (hook == 1) begin
      cyc(4); rdy[i] = 1'b1;
      cyc(1); rdy[i] = 1'b0;
      cyc(3);
    end else if (hook == 2) begin
      cyc(4); chk("valid_before_push", 32'(get_val(i)), 32'd0);
      cyc(1); chk("valid_after_push", 32'(get_val(i)), 32'd1);
      cyc(3);
    end else begin
      cyc(8);
    end
  endtask

  task automatic send_frame(input int i, input logic [15:0] data, input bit par_ok,
                            input logic stop, input int hook);
    logic [15:0] d;
    logic        pb;
    logic        perr_e;
    int          ones;
    d      = data & 16'((32'd1 << NB[i]) - 1);
    ones   = $countones(d);
    perr_e = 1'b0;
    send_bit(i, 1'b0, 0);
    for (int k = 0; k < NB[i]; k++) send_bit(i, d[k], 0);
    if (PM[i] != 0) begin
      pb = (PM[i] == 1) ? 1'(ones % 2) : ~1'(ones % 2);
      if (!par_ok) pb = ~pb;
      send_bit(i, pb, 0);
      perr_e = (PM[i] == 1) ? (((ones + int'(pb)) % 2) != 0) : (((ones + int'(pb)) % 2) == 0);
    end
    if (qsize(i) < DEPTH || hook == 1) push_exp(i, {~stop, perr_e, d});
    else exp_ovf[i] = 1'b1;
    send_bit(i, stop, hook);
    send_bit(i, 1'b1, 0);
    $display("frame u%0d data=%0h parity_ok=%0d stop=%0d", i, d, par_ok, stop);
  endtask

  always @(negedge clk) begin
    if (rst && val0 && rdy[0]) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL u0_extra_word: got %0h expected none", dout0);
      end else begin
        logic [17:0] e;
        e = q0.pop_front();
        chk("u0_word", 32'({ferr0, perr0, 8'h00, dout0}), 32'(e));
        $display("pop u0 dout=%0h perr=%0d ferr=%0d", dout0, perr0, ferr0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && val1 && rdy[1]) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL u1_extra_word: got %0h expected none", dout1);
      end else begin
        logic [17:0] e;
        e = q1.pop_front();
        chk("u1_word", 32'({ferr1, perr1, 8'h00, dout1}), 32'(e));
        $display("pop u1 dout=%0h perr=%0d ferr=%0d", dout1, perr1, ferr1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && val2 && rdy[2]) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL u2_extra_word: got %0h expected none", dout2);
      end else begin
        logic [17:0] e;
        e = q2.pop_front();
        chk("u2_word", 32'({ferr2, perr2, 4'h0, dout2}), 32'(e));
        $display("pop u2 dout=%0h perr=%0d ferr=%0d", dout2, perr2, ferr2);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx[i] = 1'b1; uclk[i] = 1'b1; rdy[i] = 1'b0; oclr[i] = 1'b0; exp_ovf[i] = 1'b0;
    end
    cyc(3);
    chk("rst_valid0", 32'(val0), 32'd0);
    chk("rst_dout0", 32'(dout0), 32'd0);
    chk("rst_flags0", 32'({perr0, ferr0}), 32'd0);
    chk("rst_ovf0", 32'(ovf0), 32'd0);
    chk("rst_valid12", 32'({val1, val2}), 32'd0);
    chk("rst_dout2", 32'(dout2), 32'd0);
    rst = 1'b1;
    cyc(3);

    // Basic word with valid latency, then pop empties the FIFO.
    send_frame(0, 16'hA5, 1'b1, 1'b1, 2);
    rdy[0] = 1'b1; cyc(2); rdy[0] = 1'b0;
    chk("t1_empty_after_pop", 32'(val0), 32'd0);
    chk("t1_queue_drained", 32'(q0.size()), 32'd0);

    // Parity even and odd.
    rdy[1] = 1'b1; rdy[2] = 1'b1;
    send_frame(1, 16'h3C, 1'b1, 1'b1, 0);
    send_frame(1, 16'h3C, 1'b0, 1'b1, 0);
    send_frame(2, 16'h001, 1'b1, 1'b1, 0);

    // Framing error followed by a clean frame.
    rdy[0] = 1'b1;
    send_frame(0, 16'h55, 1'b1, 1'b0, 0);
    send_frame(0, 16'h0F, 1'b1, 1'b1, 0);
    cyc(4);

    // Overflow: five words into a four-entry FIFO.
    rdy[0] = 1'b0;
    for (int v = 1; v <= 5; v++) send_frame(0, 16'(v), 1'b1, 1'b1, 0);
    chk("t4_ovf_set", 32'(ovf0), 32'(exp_ovf[0]));
    chk("t4_valid_full", 32'(val0), 32'd1);
    rdy[0] = 1'b1; cyc(8); rdy[0] = 1'b0;
    chk("t4_drained", 32'(q0.size()), 32'd0);
    chk("t4_valid_empty", 32'(val0), 32'd0);
    oclr[0] = 1'b1; cyc(1); oclr[0] = 1'b0; exp_ovf[0] = 1'b0;
    chk("t4_ovf_cleared", 32'(ovf0), 32'd0);

    // Full FIFO with a pop on the push cycle: no drop.
    for (int v = 1; v <= 4; v++) send_frame(0, 16'(v), 1'b1, 1'b1, 0);
    send_frame(0, 16'h77, 1'b1, 1'b1, 1);
    chk("t5_no_ovf", 32'(ovf0), 32'(exp_ovf[0]));
    chk("t5_queue_depth", 32'(q0.size()), 32'd4);
    rdy[0] = 1'b1; cyc(8);
    chk("t5_drained", 32'(q0.size()), 32'd0);

    // Reset mid-frame discards the partial word.
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    rx[0] = 1'b1;
    rst = 1'b0; cyc(2);
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) exp_ovf[i] = 1'b0;
    rst = 1'b1; cyc(2);
    send_bit(0, 1'b1, 0);
    send_frame(0, 16'h5A, 1'b1, 1'b1, 0);
    cyc(4);
    chk("t6_one_word", 32'(q0.size()), 32'd0);
    chk("t6_valid_empty", 32'(val0), 32'd0);
    send_frame(2, 16'hABC, 1'b1, 1'b1, 0);

    // Randomised frames on all three configurations.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        send_frame(i, 16'($urandom), ($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 3) != 0), 0);
      end
    end
    cyc(10);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("final_drain_u%0d", i), 32'(qsize(i)), 32'd0);
      chk($sformatf("final_ovf_u%0d", i), 32'(get_ovf(i)), 32'(exp_ovf[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
